// File: rtl/spi_mux_multi.sv
// rtl/spi_mux_multi.sv - clk-domain SPI slave driving CHANNELS output registers with mask, status and readback
// First word of a frame is a command: bit WIDTH-1 set loads the enable mask, clear selects a start channel.
module spi_mux_multi #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      spi_nCS,
  input  logic                      spi_sck,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       out_en,
  output logic                      buffer_oe,
  output logic [2:0]                status
);
  localparam int CW  = $clog2(WIDTH);
  localparam int CHW = $clog2(CHANNELS);
  localparam logic [WIDTH-1:0] CMD_TX = {3'b001, {(WIDTH-3){1'b0}}};

  typedef enum logic [1:0] {IDLE, CMD, DATA, DROP} state_t;

  logic [SYNC_STAGES-1:0]     ncs_sync_q, sck_sync_q, mosi_sync_q;
  logic                       ncs_prev_q, sck_prev_q;
  state_t                     state_q;
  logic [CW-1:0]              bit_cnt_q;
  logic [WIDTH-2:0]           shift_q;
  logic [WIDTH-1:0]           tx_q;
  logic [CHW-1:0]             ch_q;
  logic [CHANNELS*WIDTH-1:0]  out_q;
  logic [CHANNELS-1:0]        out_en_q;
  logic                       buffer_oe_q, bad_chan_q, frame_err_q, busy_q, miso_q;

  logic             ncs_s, sck_s, mosi_s;
  logic             ncs_fall, ncs_rise, sck_rise, sck_fall, word_done, bad_cmd;
  logic [WIDTH-1:0] word_d;
  logic [CHW-1:0]   cmd_ch, ch_next;

  // Reset the nCS chain low so a held-low nCS after reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ncs_sync_q  <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ncs_prev_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_nCS};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      ncs_prev_q  <= ncs_s;
      sck_prev_q  <= sck_s;
    end
  end

  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ncs_fall  = ncs_prev_q & ~ncs_s;
  assign ncs_rise  = ~ncs_prev_q & ncs_s;
  assign sck_rise  = ~sck_prev_q & sck_s & (state_q != IDLE);
  assign sck_fall  = sck_prev_q & ~sck_s & (state_q != IDLE);
  assign word_done = sck_rise & (bit_cnt_q == CW'(WIDTH-1));
  assign word_d    = {shift_q, mosi_s};
  assign cmd_ch    = word_d[CHW-1:0];
  assign bad_cmd   = word_d[WIDTH-2:0] >= (WIDTH-1)'(CHANNELS);
  assign ch_next   = (ch_q == CHW'(CHANNELS-1)) ? '0 : ch_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ch_q        <= '0;
      out_q       <= '0;
      out_en_q    <= '0;
      buffer_oe_q <= 1'b0;
      bad_chan_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      buffer_oe_q <= |out_en_q;
      if (state_q == IDLE) begin
        if (ncs_fall) begin
          state_q     <= CMD;
          bit_cnt_q   <= '0;
          bad_chan_q  <= 1'b0;
          frame_err_q <= 1'b0;
          busy_q      <= 1'b1;
          miso_q      <= CMD_TX[WIDTH-1];
          tx_q        <= {CMD_TX[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (sck_rise) begin
          shift_q   <= word_d[WIDTH-2:0];
          bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
        end
        if (sck_fall) begin
          miso_q <= tx_q[WIDTH-1];
          tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
        end
        // tx_q is reloaded with the next word's readback so the following SCK fall shows its MSB.
        if (word_done) begin
          case (state_q)
            CMD: begin
              if (word_d[WIDTH-1]) begin
                out_en_q <= word_d[CHANNELS-1:0];
                state_q  <= DROP;
                tx_q     <= '0;
              end else begin
                ch_q <= cmd_ch;
                if (bad_cmd) begin
                  bad_chan_q <= 1'b1;
                  state_q    <= DROP;
                  tx_q       <= '0;
                end else begin
                  state_q <= DATA;
                  tx_q    <= out_q[cmd_ch*WIDTH +: WIDTH];
                end
              end
            end
            DATA: begin
              out_q[ch_q*WIDTH +: WIDTH] <= word_d;
              ch_q <= ch_next;
              tx_q <= out_q[ch_next*WIDTH +: WIDTH];
            end
            default: tx_q <= '0;
          endcase
        end
        if (ncs_rise) begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          miso_q    <= 1'b0;
          tx_q      <= '0;
          bit_cnt_q <= '0;
          if ((bit_cnt_q != '0) && !word_done) frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign spi_miso  = miso_q;
  assign out       = out_q;
  assign out_en    = out_en_q;
  assign buffer_oe = buffer_oe_q;
  assign status    = {bad_chan_q, frame_err_q, busy_q};
endmodule

// File: tb/tb_spi_mux_multi.sv
// tb/tb_spi_mux_multi.sv - randomized scoreboard bench for spi_mux_multi
// Driver acts as SPI master; a monitor checks registers and MISO words whenever busy drops.
module tb_spi_mux_multi;
  localparam int HALF = 6;

  logic        clk, reset, spi_nCS, spi_sck, spi_mosi, spi_miso, buffer_oe;
  logic [31:0] out;
  logic [3:0]  out_en;
  logic [2:0]  status;

  spi_mux_multi #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi_nCS(spi_nCS), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .out(out), .out_en(out_en), .buffer_oe(buffer_oe), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic [3:0]  en;
    logic [2:0]  st;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] miso_exp[$];
  logic [7:0] miso_act[$];
  logic [7:0] frame_w [0:7];
  logic [7:0] m_out [0:3];
  logic [3:0] m_en;
  logic       busy_prev;
  int         n_vec, n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: walks the frame word by word using the command/data rules.
  task automatic model_frame(input int nw, input int nextra);
    int   mode, ch;
    logic bad, fe;
    exp_t e;
    mode = 0; ch = 0; bad = 1'b0; fe = 1'b0;
    for (int w = 0; w < nw; w++) begin
      if (mode == 0) begin
        miso_exp.push_back(8'h20);
        if (frame_w[w][7]) begin
          m_en = frame_w[w][3:0];
          mode = 2;
        end else begin
          ch = int'(frame_w[w][1:0]);
          if (int'(frame_w[w][6:0]) >= 4) begin
            bad  = 1'b1;
            mode = 2;
          end else mode = 1;
        end
      end else if (mode == 1) begin
        miso_exp.push_back(m_out[ch]);
        m_out[ch] = frame_w[w];
        ch = (ch + 1) % 4;
      end else begin
        miso_exp.push_back(8'h00);
      end
    end
    if (nextra > 0) fe = 1'b1;
    e.out = {m_out[3], m_out[2], m_out[1], m_out[0]};
    e.en  = m_en;
    e.st  = {bad, fe, 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input int nw, input int nextra, input bit together);
    logic [7:0] cap;
    int         nb;
    cap = 8'h00;
    spi_nCS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int w = 0; w < nw + ((nextra > 0) ? 1 : 0); w++) begin
      nb = (w < nw) ? 8 : nextra;
      for (int b = 0; b < nb; b++) begin
        spi_mosi = frame_w[w][7-b];
        repeat (HALF) @(negedge clk);
        cap = {cap[6:0], spi_miso};
        if (w < nw && b == 7) miso_act.push_back(cap);
        spi_sck = 1'b1;
        if (together && w == nw - 1 && b == 7) spi_nCS = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk);
    spi_nCS = 1'b1;
    repeat (HALF + 6) @(negedge clk);
  endtask

  task automatic run_frame(input int nw, input int nextra, input bit together);
    model_frame(nw, nextra);
    send_frame(nw, nextra, together);
  endtask

  task automatic sck_bit(input logic b);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  initial begin
    exp_t       e;
    logic [7:0] a, x;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && busy_prev && !status[0]) begin
        if (exp_q.size() == 0) begin
          check("frame_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("out", 64'(out), 64'(e.out));
          check("out_en", 64'(out_en), 64'(e.en));
          check("status", 64'(status), 64'(e.st));
          check("miso_words", 64'(miso_act.size()), 64'(miso_exp.size()));
          while (miso_act.size() > 0 && miso_exp.size() > 0) begin
            a = miso_act.pop_front();
            x = miso_exp.pop_front();
            check("miso", 64'(a), 64'(x));
          end
          miso_act.delete();
          miso_exp.delete();
          @(negedge clk);
          check("buffer_oe", 64'(buffer_oe), 64'(|e.en));
        end
      end
      busy_prev = status[0];
    end
  end

  initial begin
    int nw, kind, nextra;
    bit tog;
    n_vec = 0; n_err = 0;
    reset = 1'b1; spi_nCS = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    m_en = 4'h0;
    repeat (5) @(negedge clk);
    check("rst_out", 64'(out), 64'd0);
    check("rst_out_en", 64'(out_en), 64'd0);
    check("rst_buffer_oe", 64'(buffer_oe), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_miso", 64'(spi_miso), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    frame_w[0] = 8'h01; frame_w[1] = 8'hA5; frame_w[2] = 8'h3C;
    run_frame(3, 0, 1'b0);
    frame_w[0] = 8'h03; frame_w[1] = 8'h11; frame_w[2] = 8'h22;
    run_frame(3, 0, 1'b0);
    frame_w[0] = 8'h85;
    run_frame(1, 0, 1'b0);
    frame_w[0] = 8'h07; frame_w[1] = 8'hFF;
    run_frame(2, 0, 1'b0);
    frame_w[0] = 8'h00; frame_w[1] = 8'hF8;
    run_frame(1, 5, 1'b0);
    frame_w[0] = 8'h02; frame_w[1] = 8'h99;
    run_frame(2, 0, 1'b1);

    for (int f = 0; f < 40; f++) begin
      nw     = $urandom_range(0, 5);
      kind   = $urandom_range(0, 3);
      nextra = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      tog    = (nextra == 0 && nw > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (kind == 0)      frame_w[0] = 8'h80 | 8'($urandom_range(0, 127));
      else if (kind == 1) frame_w[0] = 8'($urandom_range(4, 127));
      else                frame_w[0] = 8'($urandom_range(0, 3));
      for (int i = 1; i < 8; i++) frame_w[i] = 8'($urandom);
      run_frame(nw, nextra, tog);
    end

    // Reset in the middle of a data word with nCS held low.
    spi_nCS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) sck_bit(1'b0);
    for (int i = 0; i < 3; i++) sck_bit(1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_out_en", 64'(out_en), 64'd0);
    check("midrst_buffer_oe", 64'(buffer_oe), 64'd0);
    check("midrst_status", 64'(status), 64'd0);
    check("midrst_miso", 64'(spi_miso), 64'd0);
    for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    m_en = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) sck_bit(1'b1);
    repeat (HALF) @(negedge clk);
    check("post_rst_status", 64'(status), 64'd0);
    check("post_rst_out", 64'(out), 64'd0);
    spi_nCS = 1'b1;
    repeat (HALF) @(negedge clk);
    frame_w[0] = 8'h02; frame_w[1] = 8'h5A; frame_w[2] = 8'h77;
    run_frame(3, 0, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
